div_top_5: RTL



---
 rtl/div_top_5.sv | 123 ++++++++++++
 1 files changed

// File: rtl/div_top_5.sv
// rtl/div_top_5.sv - sequential unsigned radix-2 restoring divider, one quotient bit per clock
module div_top_5 #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  result_rdy
);

    localparam int CNT_W = $clog2(DIVIDEND_W) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DIVIDEND_W-1:0] shift_q, shift_d;
    logic [DIVISOR_W-1:0]  dvsr_q, dvsr_d;
    logic [DIVISOR_W:0]    prem_q, prem_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  zero_q, zero_d;
    logic [DIVIDEND_W-1:0] quot_q, quot_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic                  dbz_q, dbz_d;
    logic                  rdy_q, rdy_d;

    logic [DIVISOR_W:0]    trial;
    logic [DIVISOR_W:0]    diff;
    logic                  q_bit;
    logic                  accept;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        dvsr_d  = dvsr_q;
        prem_d  = prem_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        rdy_d   = 1'b0;

        trial  = {prem_q[DIVISOR_W-1:0], shift_q[DIVIDEND_W-1]};
        diff   = trial - {1'b0, dvsr_q};
        // The partial remainder always stays below the divisor, so its top bit
        // only matters as a guard: if it were ever set the trial would exceed the divisor.
        q_bit  = prem_q[DIVISOR_W] | (trial >= {1'b0, dvsr_q});
        accept = en && (state_q != RUN);

        case (state_q)
            RUN: begin
                shift_d = {shift_q[DIVIDEND_W-2:0], q_bit};
                prem_d  = q_bit ? diff : trial;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                    // With a zero divisor every trial passes, so the remainder
                    // naturally ends up as the low dividend bits.
                    quot_d  = zero_q ? '1 : shift_d;
                    rem_d   = prem_d[DIVISOR_W-1:0];
                    dbz_d   = zero_q;
                    rdy_d   = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d = RUN;
            shift_d = dividend;
            dvsr_d  = divisor;
            prem_d  = '0;
            cnt_d   = '0;
            zero_d  = (divisor == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            dvsr_q  <= '0;
            prem_q  <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            dvsr_q  <= dvsr_d;
            prem_q  <= prem_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            rdy_q   <= rdy_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign result_rdy  = rdy_q;

endmodule
